// File: rtl/dmem_ctrl_pkg.sv
// Shared types and defaults for the data-memory controller slice.
// Optional access-error reporting is enabled with the DMEM_ERR_EN macro.
package dmem_ctrl_pkg;

    localparam int WORD_WIDTH       = 32;
    localparam int DMEM_DEPTH       = 1024;
    localparam int DMEM_WAIT_STATES = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] addr;
        logic                  we;
        logic [3:0]            be;
        logic [WORD_WIDTH-1:0] wdata;
    } dmem_req_t;

    // A lane enabled below the byte offset means the strobe does not start at the addressed byte.
    function automatic logic be_misaligned(input logic [1:0] off, input logic [3:0] be);
        logic [3:0] low_mask;
        low_mask = (4'b0001 << off) - 4'b0001;
        return (be & low_mask) != 4'b0000;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the MMU data port (master) and the data memory (slave).
interface dmem_ctrl_if;
    import dmem_ctrl_pkg::*;

    logic                  data_req;
    logic [WORD_WIDTH-1:0] data_addr;
    logic                  data_we;
    logic [3:0]            data_be;
    logic [WORD_WIDTH-1:0] data_wdata;
    logic                  data_gnt;
    logic                  data_rvalid;
    logic [WORD_WIDTH-1:0] data_rdata;
    logic                  data_err;

    modport master (
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_err
    );

    modport slave (
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_err
    );

endinterface

// File: rtl/dmem_ctrl_sram.sv
// Single-port DEPTH x WORD_WIDTH data array with per-byte write enables and a registered read port.
module dmem_sram
    import dmem_ctrl_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     i_en,
    input  logic                     i_we,
    input  logic [3:0]               i_be,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WORD_WIDTH-1:0]    i_wdata,
    output logic [WORD_WIDTH-1:0]    o_rdata
);

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic [WORD_WIDTH-1:0] r_q;

    // Array contents are deliberately left unreset; the read register only loads on reads.
    always_ff @(posedge clk_i) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_q <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: grant/wait-state FSM with one outstanding transaction in front of dmem_sram.
// Define DMEM_ERR_EN to report out-of-range and misaligned-strobe accesses on data_err.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DEPTH       = DMEM_DEPTH,
    parameter int WAIT_STATES = DMEM_WAIT_STATES
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dmem_ctrl_if.slave  bus
);

    localparam int                    AW    = $clog2(DEPTH);
    localparam logic [WORD_WIDTH-1:0] LIMIT = WORD_WIDTH'(DEPTH * 4);

    dmem_state_e           r_state;
    logic [3:0]            r_cnt;
    dmem_req_t             r_req;
    logic                  r_rvalid;
    logic                  r_zero;
    dmem_req_t             w_in;
    dmem_req_t             w_acc;
    logic                  w_gnt;
    logic                  w_access;
    logic                  w_oor;
    logic                  w_drop;
    logic [WORD_WIDTH-1:0] w_q;
`ifdef DMEM_ERR_EN
    logic                  r_err;
    logic                  w_err;
`endif

    assign w_in.addr  = bus.data_addr;
    assign w_in.we    = bus.data_we;
    assign w_in.be    = bus.data_be;
    assign w_in.wdata = bus.data_wdata;

    assign w_gnt = bus.data_req && !rst_i && (r_state == IDLE || r_state == RESP);

    // Zero wait states access the array on the grant edge with the live request.
    assign w_acc    = (WAIT_STATES == 0) ? w_in : r_req;
    assign w_access = (WAIT_STATES == 0) ? w_gnt : (r_state == WAIT && r_cnt == 4'd1);
    assign w_oor    = w_acc.addr >= LIMIT;

`ifdef DMEM_ERR_EN
    assign w_err  = w_oor || (w_acc.addr[1:0] != 2'b00 && be_misaligned(w_acc.addr[1:0], w_acc.be));
    assign w_drop = w_err;
`else
    assign w_drop = w_oor;
`endif

    // Control FSM: capture on grant, count wait states, pulse the response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_req    <= '0;
            r_rvalid <= 1'b0;
            r_zero   <= 1'b1;
`ifdef DMEM_ERR_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_rvalid <= w_access;
            if (w_access) begin
                r_zero <= w_acc.we || w_drop;
`ifdef DMEM_ERR_EN
                r_err  <= w_err;
`endif
            end
            case (r_state)
                IDLE, RESP: begin
                    if (w_gnt) begin
                        r_req   <= w_in;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_state <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    dmem_sram #(.DEPTH(DEPTH)) u_sram (
        .clk_i   (clk_i),
        .i_en    (w_access && !w_drop),
        .i_we    (w_acc.we),
        .i_be    (w_acc.be),
        .i_addr  (w_acc.addr[AW+1:2]),
        .i_wdata (w_acc.wdata),
        .o_rdata (w_q)
    );

    // Writes and dropped accesses respond with zero while the array read register keeps its last word.
    assign bus.data_gnt    = w_gnt;
    assign bus.data_rvalid = r_rvalid;
    assign bus.data_rdata  = r_zero ? '0 : w_q;
`ifdef DMEM_ERR_EN
    assign bus.data_err    = r_err;
`else
    assign bus.data_err    = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with one wait state, one with zero wait states.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    dmem_ctrl_if bus1 ();
    dmem_ctrl_if bus0 ();

    dmem_ctrl #(.DEPTH(1024), .WAIT_STATES(1)) u_dut_ws1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    dmem_ctrl #(.DEPTH(1024), .WAIT_STATES(0)) u_dut_ws0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DMEM_ERR_EN
    localparam logic OOR_ERR = 1'b1;
`else
    localparam logic OOR_ERR = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the one-wait-state instance; entered and left at posedge+1.
    task automatic txn1(input string tag, input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        bus1.data_req   = 1'b1;
        bus1.data_we    = we;
        bus1.data_addr  = addr;
        bus1.data_be    = be;
        bus1.data_wdata = wd;
        #1;
        chk({tag, ".gnt"}, 32'(bus1.data_gnt), 32'd1);
        step();
        bus1.data_req = 1'b0;
        #1;
        chk({tag, ".gnt_wait"}, 32'(bus1.data_gnt), 32'd0);
        chk({tag, ".rvalid_early"}, 32'(bus1.data_rvalid), 32'd0);
        step();
        #1;
        chk({tag, ".rvalid"}, 32'(bus1.data_rvalid), 32'd1);
        chk({tag, ".rdata"}, bus1.data_rdata, exp_rd);
        chk({tag, ".err"}, 32'(bus1.data_err), 32'(exp_err));
        step();
        chk({tag, ".rvalid_end"}, 32'(bus1.data_rvalid), 32'd0);
    endtask

    logic [31:0] wv [3];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        wv[0] = 32'hA0A0_0001;
        wv[1] = 32'hB0B0_0002;
        wv[2] = 32'hC0C0_0003;

        bus1.data_req = 1'b1; bus1.data_we = 1'b0; bus1.data_addr = 32'h0; bus1.data_be = 4'hF; bus1.data_wdata = 32'h0;
        bus0.data_req = 1'b1; bus0.data_we = 1'b0; bus0.data_addr = 32'h0; bus0.data_be = 4'hF; bus0.data_wdata = 32'h0;
        rst = 1'b1;

        // Reset held with requests pending: nothing granted, nothing returned.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst.gnt1", 32'(bus1.data_gnt), 32'd0);
            chk("rst.gnt0", 32'(bus0.data_gnt), 32'd0);
            chk("rst.rvalid", 32'(bus1.data_rvalid), 32'd0);
            chk("rst.rdata", bus1.data_rdata, 32'd0);
            chk("rst.err", 32'(bus1.data_err), 32'd0);
        end
        bus0.data_req = 1'b0;
        rst = 1'b0;

        txn1("wr10", 1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
        txn1("rd10", 1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0);
        txn1("wr20a", 1'b1, 32'h20, 4'b1111, 32'h0000_0000, 32'h0, 1'b0);
        txn1("wr20b", 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b0);
        txn1("rd20", 1'b0, 32'h20, 4'b1111, 32'h0, 32'h00BB_00DD, 1'b0);
        txn1("rd13", 1'b0, 32'h13, 4'b1000, 32'h0, 32'hDEAD_BEEF, 1'b0);
        txn1("wr00", 1'b1, 32'h00, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);
        txn1("wr1000", 1'b1, 32'h1000, 4'b1111, 32'h1234_5678, 32'h0, OOR_ERR);
        txn1("rd1000", 1'b0, 32'h1000, 4'b1111, 32'h0, 32'h0, OOR_ERR);
        txn1("rd00", 1'b0, 32'h00, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);
        txn1("wr3ffc", 1'b1, 32'hFFC, 4'b1111, 32'h5A5A_A5A5, 32'h0, 1'b0);
        txn1("rd3ffc", 1'b0, 32'hFFC, 4'b1111, 32'h0, 32'h5A5A_A5A5, 1'b0);

        // Zero wait states: back-to-back writes then reads, one per cycle.
        for (int k = 0; k < 3; k++) begin
            bus0.data_req = 1'b1; bus0.data_we = 1'b1; bus0.data_addr = 32'(4 * k);
            bus0.data_be = 4'hF; bus0.data_wdata = wv[k];
            #1;
            chk("b2b_wr.gnt", 32'(bus0.data_gnt), 32'd1);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            bus0.data_req  = (k < 3) ? 1'b1 : 1'b0;
            bus0.data_we   = 1'b0;
            bus0.data_addr = 32'(4 * k);
            #1;
            chk("b2b_rd.gnt", 32'(bus0.data_gnt), (k < 3) ? 32'd1 : 32'd0);
            chk("b2b_rd.rvalid", 32'(bus0.data_rvalid), 32'd1);
            chk("b2b_rd.rdata", bus0.data_rdata, (k == 0) ? 32'h0 : wv[k-1]);
            step();
        end
        #1;
        chk("b2b_rd.rvalid_end", 32'(bus0.data_rvalid), 32'd0);
        step();
        bus0.data_req = 1'b1; bus0.data_we = 1'b0; bus0.data_addr = 32'h1000;
        #1;
        chk("ws0_oor.gnt", 32'(bus0.data_gnt), 32'd1);
        step();
        bus0.data_req = 1'b0;
        #1;
        chk("ws0_oor.rvalid", 32'(bus0.data_rvalid), 32'd1);
        chk("ws0_oor.rdata", bus0.data_rdata, 32'd0);
        chk("ws0_oor.err", 32'(bus0.data_err), 32'(OOR_ERR));
        step();

        // Reset during the wait state of a write: the write is lost and no response appears.
        txn1("wr30", 1'b1, 32'h30, 4'b1111, 32'h1111_1111, 32'h0, 1'b0);
        bus1.data_req = 1'b1; bus1.data_we = 1'b1; bus1.data_addr = 32'h30;
        bus1.data_be = 4'hF; bus1.data_wdata = 32'h2222_2222;
        #1;
        chk("abort.gnt", 32'(bus1.data_gnt), 32'd1);
        step();
        bus1.data_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort.rvalid0", 32'(bus1.data_rvalid), 32'd0);
        step();
        chk("abort.rvalid1", 32'(bus1.data_rvalid), 32'd0);
        step();
        chk("abort.rvalid2", 32'(bus1.data_rvalid), 32'd0);
        rst = 1'b0;
        txn1("rd30", 1'b0, 32'h30, 4'b1111, 32'h0, 32'h1111_1111, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
